sfr_master_ctrl: RTL
====================

Name: sfr_master_ctrl

Overview:
- Synthesizable, parametrised SFR bus master for the SFR register bus (address, write_data, read_data, we, re).
- Arbitrates NUM_CH requester channels round-robin and issues one single-cycle SFR access per command.
- Captures read data after a configurable read latency and returns a tagged response over a valid/ready handshake.
- Sits between on-chip requesters (CPU bridge, DMA, test port) and the SFR slave fabric.

Parameters:
ADDR_WIDTH, 8, SFR address width
DATA_WIDTH, 8, SFR data width
NUM_CH, 2, requester channel count (1..8)
READ_LATENCY, 1, clocks from the re-asserting edge to the read_data sampling edge (1..4)
MAX_WAIT, 15, wait-cycle limit before timeout (used only with SFR_MASTER_WAIT_EN)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
cmd_valid  input  NUM_CH  per-channel command valid
cmd_ready  output  NUM_CH  per-channel accept, at most one bit high
cmd_we  input  NUM_CH  per-channel: 1 = write, 0 = read
cmd_addr  input  NUM_CH*ADDR_WIDTH  packed addresses, channel k at [k*ADDR_WIDTH +: ADDR_WIDTH]
cmd_wdata  input  NUM_CH*DATA_WIDTH  packed write data
rsp_valid  output  1  response valid
rsp_ready  input  1  response accept
rsp_ch  output  $clog2(NUM_CH) min 1  channel id of response
rsp_we  output  1  response is for a write
rsp_rdata  output  DATA_WIDTH  read data (0 for writes)
rsp_err  output  1  timeout error (constant 0 without the optional feature)
address  output  ADDR_WIDTH  SFR address
write_data  output  DATA_WIDTH  SFR write data
read_data  input  DATA_WIDTH  SFR read data
we  output  1  SFR write strobe
re  output  1  SFR read strobe

Behaviour:
- Reset (reset=0, async): all outputs 0, state IDLE, round-robin pointer 0. Reset mid-access aborts it: strobes drop immediately and any pending response is discarded.
- FSM states: IDLE, STROBE, RDWAIT, RESP.
- IDLE: the arbiter picks the first valid channel starting at the pointer and scanning upward with wrap. Its cmd_ready is high combinationally in the same cycle.
- On accept: latch channel, we, addr and wdata. Pointer = grant+1 mod NUM_CH. Go to STROBE.
- STROBE (exactly 1 cycle): address/write_data driven from the latch; we=cmd_we, re=!cmd_we.
- STROBE, write: go to RESP.
- STROBE, read, READ_LATENCY=1: sample read_data at the end of STROBE, then go to RESP.
- STROBE, read, READ_LATENCY>1: go to RDWAIT with a counter and sample read_data on the READ_LATENCY-th edge after re rose.
- re and we are never high outside STROBE. address/write_data hold their last value after the access.
- RESP: rsp_valid=1 with rsp_ch, rsp_we and rsp_rdata stable until rsp_ready. On rsp_valid&rsp_ready, return to IDLE.
- cmd_ready is 0 in every state except IDLE.
- Throughput: write turnaround is 3 cycles accept-to-accept with rsp_ready tied high. Read turnaround is 2+READ_LATENCY.
- Stalled rsp_ready blocks all channels; there is no command queueing.
- A channel whose cmd_valid drops before grant is skipped without error.

Optional Feature:
SFR_MASTER_WAIT_EN
- Defined: adds input sfr_wait (1 bit). While sfr_wait=1 during STROBE, the strobes and address are held and the latency counter is frozen.
- Defined, timeout: if wait lasts MAX_WAIT consecutive cycles, the strobes drop and the FSM goes to RESP with rsp_err=1 and rsp_rdata=0.
- Undefined: no sfr_wait port and rsp_err is tied 0.

Decomposition:
- Package sfr_master_pkg:
  - state enum type sfr_master_state_e.
  - localparam helper for channel-id width.
  - response struct sfr_rsp_t (ch, we, rdata, err).
- One sub-module: sfr_rr_arbiter, parametrised on NUM_CH. Inputs: request vector and pointer. Outputs: one-hot grant and grant index.

Test Plan:
- Reset during STROBE of a write to 0x3C: we drops asynchronously, no rsp_valid; after release the FSM is IDLE and the pointer is 0.
- NUM_CH=1, write addr 0x10 data 0xA5: we=1 for exactly one cycle with address=0x10 and write_data=0xA5; rsp_valid on the next cycle with rsp_we=1 and rsp_rdata=0.
- READ_LATENCY=3, read 0x22 with the slave returning 0x5A three edges after re: rsp_rdata=0x5A; re high for exactly 1 cycle; accept-to-accept 5 cycles.
- NUM_CH=4, all channels valid continuously: grants follow 0,1,2,3,0. With only ch1 and ch3 valid, grants alternate 1,3,1.
- rsp_ready held low for 6 cycles: rsp_valid and its fields are stable, cmd_ready stays 0, and there is no bus activity.
- SFR_MASTER_WAIT_EN, MAX_WAIT=15, sfr_wait held high: strobe held for 15 cycles, then rsp_err=1 and rsp_rdata=0. With sfr_wait high for 2 cycles: normal response with a 2-cycle stretch.

Source files
------------

// File: rtl/sfr_master_ctrl_pkg.sv
// Shared types for the SFR bus master: FSM state encoding, response record
// and the channel-id width helper.
package sfr_master_pkg;

    localparam int SFR_CH_W_MAX = 3;   // up to 8 requester channels
    localparam int SFR_DW_MAX   = 32;
    localparam int SFR_LAT_W    = 2;   // read latency 1..4 needs at most 2 bits of countdown

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_RDWAIT = 2'd2,
        ST_RESP   = 2'd3
    } sfr_master_state_e;

    typedef struct packed {
        logic [SFR_CH_W_MAX-1:0] ch;
        logic                    we;
        logic [SFR_DW_MAX-1:0]   rdata;
        logic                    err;
    } sfr_rsp_t;

    function automatic int sfr_ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sfr_master_ctrl_rr_arbiter.sv
// Round-robin arbiter: first requester at or above the pointer, wrapping,
// returned both one-hot and as an index.
module sfr_rr_arbiter
    import sfr_master_pkg::*;
#(
    parameter  int NUM_CH = 2,
    localparam int CH_W   = sfr_ch_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [CH_W-1:0]   i_ptr,
    output logic [NUM_CH-1:0] o_gnt,
    output logic [CH_W-1:0]   o_gnt_idx
);

    logic [NUM_CH-1:0] w_rot;

    // Rotate so the pointer channel sits at bit 0; the scan is then a plain
    // priority pick from the bottom.
    assign w_rot = NUM_CH'({i_req, i_req} >> i_ptr);

    always_comb begin
        int   idx;
        logic found;
        o_gnt     = '0;
        o_gnt_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && w_rot[i]) begin
                found = 1'b1;
                idx   = int'(i_ptr) + i;
                if (idx >= NUM_CH) idx = idx - NUM_CH;
            end
        end
        o_gnt_idx = CH_W'(idx);
        for (int k = 0; k < NUM_CH; k++) begin
            o_gnt[k] = found && (k == idx);
        end
    end

endmodule

// File: rtl/sfr_master_ctrl.sv
// SFR bus master: round-robin command arbitration, single-cycle SFR strobe,
// tagged response handshake. Optional slave wait/timeout via SFR_MASTER_WAIT_EN.
//
// state     | meaning
// IDLE      | arbitrate, cmd_ready to the granted channel
// STROBE    | we or re asserted with latched address/data
// RDWAIT    | read latency countdown before sampling read_data
// RESP      | rsp_valid held until rsp_ready
module sfr_master_ctrl
    import sfr_master_pkg::*;
#(
    parameter  int ADDR_WIDTH   = 8,
    parameter  int DATA_WIDTH   = 8,
    parameter  int NUM_CH       = 2,
    parameter  int READ_LATENCY = 1,
    parameter  int MAX_WAIT     = 15,
    localparam int CH_W         = sfr_ch_w(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         reset,
`ifdef SFR_MASTER_WAIT_EN
    input  logic                         sfr_wait,
`endif
    input  logic [NUM_CH-1:0]            cmd_valid,
    output logic [NUM_CH-1:0]            cmd_ready,
    input  logic [NUM_CH-1:0]            cmd_we,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] cmd_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0] cmd_wdata,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [CH_W-1:0]              rsp_ch,
    output logic                         rsp_we,
    output logic [DATA_WIDTH-1:0]        rsp_rdata,
    output logic                         rsp_err,
    output logic [ADDR_WIDTH-1:0]        address,
    output logic [DATA_WIDTH-1:0]        write_data,
    input  logic [DATA_WIDTH-1:0]        read_data,
    output logic                         we,
    output logic                         re
);

    localparam int WCNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    sfr_master_state_e     r_state, w_state_nxt;
    sfr_rsp_t              r_rsp;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [CH_W-1:0]       r_ptr;
    logic [SFR_LAT_W-1:0]  r_lat;
    logic [WCNT_W-1:0]     r_wait_cnt;

    logic [NUM_CH-1:0]     w_gnt;
    logic [CH_W-1:0]       w_gnt_idx;
    logic [CH_W-1:0]       w_ptr_nxt;
    logic                  w_accept;
    logic                  w_wait;
    logic                  w_tmo;
    logic                  w_sample;
    logic                  w_we;
    logic                  w_re;
    logic                  w_unused;

    sfr_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .i_req     (cmd_valid),
        .i_ptr     (r_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

`ifdef SFR_MASTER_WAIT_EN
    assign w_wait   = sfr_wait;
    assign w_tmo    = sfr_wait && (r_wait_cnt == '0);
    assign rsp_err  = r_rsp.err;
    assign w_unused = ^{r_rsp.ch, r_rsp.rdata};
`else
    assign w_wait   = 1'b0;
    assign w_tmo    = 1'b0;
    assign rsp_err  = 1'b0;
    assign w_unused = ^{r_rsp.ch, r_rsp.rdata, r_rsp.err, r_wait_cnt};
`endif

    // Gated with reset so no channel sees an accept while the block is held in reset.
    assign cmd_ready  = (r_state == ST_IDLE && reset) ? w_gnt : '0;
    assign w_accept   = (r_state == ST_IDLE) && (|cmd_valid);
    assign w_ptr_nxt  = (w_gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : w_gnt_idx + 1'b1;
    assign w_sample   = (r_state == ST_STROBE && !r_rsp.we && !w_wait && READ_LATENCY == 1)
                     || (r_state == ST_RDWAIT && r_lat == '0);

    assign rsp_valid  = (r_state == ST_RESP);
    assign rsp_ch     = r_rsp.ch[CH_W-1:0];
    assign rsp_we     = r_rsp.we;
    assign rsp_rdata  = r_rsp.rdata[DATA_WIDTH-1:0];
    assign address    = r_addr;
    assign write_data = r_wdata;
    assign we         = w_we;
    assign re         = w_re;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_re        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_STROBE;
            end
            ST_STROBE: begin
                w_we = r_rsp.we;
                w_re = !r_rsp.we;
                if (w_tmo) begin
                    w_state_nxt = ST_RESP;
                end else if (!w_wait) begin
                    w_state_nxt = (r_rsp.we || READ_LATENCY == 1) ? ST_RESP : ST_RDWAIT;
                end
            end
            ST_RDWAIT: begin
                if (r_lat == '0) w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_ptr      <= '0;
            r_lat      <= '0;
            r_wait_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_rsp.ch    <= SFR_CH_W_MAX'(w_gnt_idx);
                r_rsp.we    <= cmd_we[w_gnt_idx];
                r_rsp.rdata <= '0;
                r_rsp.err   <= 1'b0;
                r_addr      <= cmd_addr[w_gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
                r_wdata     <= cmd_wdata[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];
                r_ptr       <= w_ptr_nxt;
                r_wait_cnt  <= WCNT_W'(MAX_WAIT - 1);
            end
            if (r_state == ST_STROBE) begin
                // Reloaded every strobe cycle, so a wait stretch leaves the countdown untouched.
                r_lat <= SFR_LAT_W'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);
                if (w_wait && !w_tmo) r_wait_cnt <= r_wait_cnt - 1'b1;
                if (w_tmo)            r_rsp.err  <= 1'b1;
            end
            if (r_state == ST_RDWAIT && r_lat != '0) r_lat <= r_lat - 1'b1;
            if (w_sample) r_rsp.rdata <= SFR_DW_MAX'(read_data);
        end
    end

endmodule
